// File: rtl/commutator_ctrl_pkg.sv
// Shared FFT definitions: supported size range and the per-stage configuration record.
// Imported by fft_multipoint and by every MDC stage controller.
package commutator_ctrl_pkg;

  localparam int unsigned FftMaxLog2n = 11;  // 2048-point
  localparam int unsigned FftMinLog2n = 3;   // 8-point

  typedef struct packed {
    logic [3:0] log2n;
    logic [3:0] stage;
  } fft_cfg_t;

  // A stage index s is usable only while the stage delay 2^(log2n-s-2) is at least one pair.
  function automatic logic cfg_legal(fft_cfg_t c, int unsigned max_log2n);
    int unsigned l;
    int unsigned s;
    l = 32'(c.log2n);
    s = 32'(c.stage);
    return (l >= FftMinLog2n) && (l <= max_log2n) && (s + 2 <= l);
  endfunction

endpackage

// File: rtl/commutator_ctrl.sv
// Commutator controller for one radix-2 MDC FFT stage.
// Counts accepted sample pairs within a frame and drives the external 2x2 switch and the two
// delay lines of the stage.
//   clk, rst               : clock, synchronous active-high reset
//   cfg_log2n, cfg_stage   : FFT size exponent and stage index, sampled on cfg_load
//   cfg_load               : configuration strobe (honoured only when idle and legal)
//   in_valid, in_sop       : input pair qualifier and start-of-frame marker
//   sel                    : switch control, 0 = pass-through, 1 = swap
//   dly_en                 : delay line shift enable
//   out_valid, out_sop     : switch output qualifier and first-pair marker
//   busy                   : primed or mid-frame; blocks reconfiguration
//   cfg_err                : one-cycle pulse for a rejected cfg_load
module commutator_ctrl
  import commutator_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LOG2N = FftMaxLog2n,
  parameter int unsigned CNT_W     = MAX_LOG2N - 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cfg_log2n,
  input  logic [3:0] cfg_stage,
  input  logic       cfg_load,
  input  logic       in_valid,
  input  logic       in_sop,
  output logic       sel,
  output logic       dly_en,
  output logic       out_valid,
  output logic       out_sop,
  output logic       busy,
  output logic       cfg_err
);

  fft_cfg_t         cfg_q, cfg_d, cfg_new;
  logic [CNT_W-1:0] k_q, k_d;
  logic             primed_q, primed_d;
  logic             sel_q, sel_d;
  logic             dly_en_q, dly_en_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sop_q, out_sop_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_acc;
  logic [CNT_W-1:0] k_cur, kk, mask, dval;
  logic             primed_cur;
  logic [3:0]       dsh;

  always_comb begin
    cfg_new    = '{log2n: cfg_log2n, stage: cfg_stage};
    busy       = primed_q | (k_q != '0);
    cfg_acc    = cfg_load & ~busy & cfg_legal(cfg_new, MAX_LOG2N);
    cfg_err_d  = cfg_load & ~cfg_acc;
    cfg_d      = cfg_acc ? cfg_new : cfg_q;

    // A load accepted this cycle takes effect before a coincident pair is counted.
    k_cur      = cfg_acc ? '0 : k_q;
    primed_cur = cfg_acc ? 1'b0 : primed_q;

    dsh  = cfg_d.log2n - cfg_d.stage - 4'd2;                     // log2(D)
    dval = CNT_W'(1) << dsh;                                      // D
    mask = {CNT_W{1'b1}} >> (4'(MAX_LOG2N) - cfg_d.log2n);       // L-1, no overflow at max size

    kk = in_sop ? '0 : k_cur;

    k_d         = k_cur;
    primed_d    = primed_cur;
    sel_d       = sel_q;
    dly_en_d    = 1'b0;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;

    if (in_valid) begin
      k_d         = (kk + CNT_W'(1)) & mask;
      primed_d    = primed_cur | (kk == dval - CNT_W'(1));
      sel_d       = |(kk & dval);
      dly_en_d    = 1'b1;
      // Outputs become meaningful only once the delay line holds D pairs.
      out_valid_d = primed_cur;
      out_sop_d   = primed_cur & (kk == dval);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q       <= '{log2n: 4'(MAX_LOG2N), stage: 4'd0};
      k_q         <= '0;
      primed_q    <= 1'b0;
      sel_q       <= 1'b0;
      dly_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      k_q         <= k_d;
      primed_q    <= primed_d;
      sel_q       <= sel_d;
      dly_en_q    <= dly_en_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign sel       = sel_q;
  assign dly_en    = dly_en_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_commutator_ctrl.sv
// Self-checking bench for commutator_ctrl: a behavioural model pushes the expected next-cycle
// outputs into a scoreboard queue as each cycle is driven; the monitor pops and compares.
module tb_commutator_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cfg_log2n;
  logic [3:0] cfg_stage;
  logic       cfg_load;
  logic       in_valid;
  logic       in_sop;
  logic       sel, dly_en, out_valid, out_sop, busy, cfg_err;

  always #5 clk = ~clk;

  commutator_ctrl #(
    .MAX_LOG2N (11),
    .CNT_W     (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_log2n (cfg_log2n),
    .cfg_stage (cfg_stage),
    .cfg_load  (cfg_load),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .sel       (sel),
    .dly_en    (dly_en),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  typedef struct packed {
    logic sel;
    logic dly_en;
    logic out_valid;
    logic out_sop;
    logic busy;
    logic cfg_err;
  } exp_t;

  exp_t sb_q[$];
  exp_t obs;
  int   n_vec = 0;
  int   n_err = 0;

  // Model state
  int m_log2n = 11, m_s = 0, m_k = 0;
  bit m_primed = 0, m_sel = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, predict its registered outputs, then sample them at the falling edge.
  task automatic step(input logic r, input logic ld, input int ln, input int st,
                      input logic v, input logic sop);
    exp_t e;
    int   d, l, kk;
    bit   busy_now;
    rst = r; cfg_load = ld; cfg_log2n = 4'(ln); cfg_stage = 4'(st);
    in_valid = v; in_sop = sop;
    e = '0;
    if (r) begin
      m_log2n = 11; m_s = 0; m_k = 0; m_primed = 0; m_sel = 0;
    end else begin
      busy_now = m_primed || (m_k != 0);
      if (ld) begin
        if (!busy_now && ln >= 3 && ln <= 11 && st <= ln - 2) begin
          m_log2n = ln; m_s = st; m_k = 0; m_primed = 0;
        end else begin
          e.cfg_err = 1'b1;
        end
      end
      d = 1 << (m_log2n - m_s - 2);
      l = 1 << (m_log2n - 1);
      if (v) begin
        kk          = sop ? 0 : m_k;
        e.dly_en    = 1'b1;
        e.out_valid = m_primed;
        e.out_sop   = m_primed && (kk == d);
        m_sel       = ((kk / d) % 2) == 1;
        if (kk == d - 1) m_primed = 1;
        m_k = (kk + 1) % l;
      end
      e.sel  = m_sel;
      e.busy = m_primed || (m_k != 0);
    end
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    obs = {sel, dly_en, out_valid, out_sop, busy, cfg_err};
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      check_eq("outs", 32'(obs), 32'(sb_q.pop_front()));
    end
  endtask

  initial begin
    logic [7:0] sel_v, ov_v, sop_v;
    logic [5:0] sel6, ov6;
    int         first;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 8, 0, 1, 1);  // inputs ignored under reset
    check_eq("reset_outs", 32'(obs), 32'd0);

    // N=8, s=0: D=2, L=4
    step(0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, i == 0);
      sel_v[7-i] = obs.sel; ov_v[7-i] = obs.out_valid; sop_v[7-i] = obs.out_sop;
    end
    check_eq("n8s0_sel", 32'(sel_v), 32'b00110011);
    check_eq("n8s0_valid", 32'(ov_v), 32'b00111111);
    check_eq("n8s0_sop", 32'(sop_v), 32'b00100010);
    // Load while busy is rejected, D stays 2
    step(0, 1, 4, 0, 0, 0);
    check_eq("busy_cfg_err", 32'(obs.cfg_err), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, i == 0);
    check_eq("busy_keep_d", 32'(obs.sel), 32'd1);

    // N=8, s=1: D=1, load coincident with the first pair
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, i == 0, 3, 1, 1, i == 0);
      sel6[5-i] = obs.sel; ov6[5-i] = obs.out_valid;
    end
    check_eq("n8s1_sel", 32'(sel6), 32'b010101);
    check_eq("n8s1_valid", 32'(ov6), 32'b011111);

    // N=2048, s=0: D=512
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 11, 0, 0, 0);
    first = -1;
    for (int i = 1; i <= 600; i++) begin
      step(0, 0, 0, 0, 1, i == 1);
      if (obs.out_sop && first < 0) first = i;
    end
    check_eq("n2048_sop_lat", 32'(first), 32'd513);

    // N=16, s=0 with valid gaps 1,0,0,1
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, (i % 4 == 0) || (i % 4 == 3), i == 0);

    // Illegal configurations
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 12, 0, 0, 0);
    check_eq("log2n12_err", 32'(obs.cfg_err), 32'd1);
    step(0, 1, 3, 2, 0, 0);
    check_eq("stage_err", 32'(obs.cfg_err), 32'd1);
    step(0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("err_one_shot", 32'(obs.cfg_err), 32'd0);

    // Reset at k=5, N=16: next frame primes from scratch
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, i == 0);
    step(1, 1, 4, 0, 1, 0);
    check_eq("rst_mid_outs", 32'(obs), 32'd0);
    step(0, 1, 4, 0, 0, 0);
    first = -1;
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0, 1, i == 1);
      if (obs.out_valid && first < 0) first = i;
    end
    check_eq("reprime_valid", 32'(first), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
